// File: rtl/sine_dds_pkg.sv
// Shared types and the elaboration-time quarter-wave table generator for sine_dds.
package sine_dds_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int     FX_SHIFT = 28;
    localparam longint FX_HALF  = longint'(1) <<< (FX_SHIFT - 1);
    localparam longint PI_FX    = 64'sd843314857;  // pi * 2^28

    // L[i] = round(AMAX * sin(pi/2 * (i + 0.5) / N)); Taylor series in Q28 fixed point.
    function automatic int sine_lut_entry(input int i, input int aw, input int dw);
        longint n;
        longint amax;
        longint x;
        longint x2;
        longint term;
        longint acc;
        n    = longint'(1) <<< aw;
        amax = (longint'(1) <<< (dw - 1)) - longint'(1);
        x    = (PI_FX * (longint'(2) * longint'(i) + longint'(1))) / (longint'(4) * n);
        x2   = (x * x) >>> FX_SHIFT;
        term = x;
        acc  = x;
        for (longint k = 1; k <= 7; k++) begin
            term = -((term * x2) >>> FX_SHIFT) / ((longint'(2) * k) * (longint'(2) * k + longint'(1)));
            acc  = acc + term;
        end
        return int'((amax * acc + FX_HALF) >>> FX_SHIFT);
    endfunction

endpackage

// File: rtl/sine_dds_if.sv
// Control/sample bundle between the tone controller and sine_dds.
// SINE_DDS_AMPLITUDE_EN adds the amplitude input.
interface sine_dds_if #(
    parameter int PHASE_W = 24,
    parameter int DW      = 8
);
    logic               sample_en_i;
    logic               start_i;
    logic               stop_i;
    logic               tw_load_i;
    logic [PHASE_W-1:0] tuning_word_i;
`ifdef SINE_DDS_AMPLITUDE_EN
    logic [7:0]         amplitude_i;
`endif
    logic               busy_o;
    logic [DW-1:0]      sample_out_o;
    logic [DW-2:0]      pos_out_o;
    logic [DW-2:0]      neg_out_o;
    logic               out_valid_o;

`ifdef SINE_DDS_AMPLITUDE_EN
    modport master (
        output sample_en_i, start_i, stop_i, tw_load_i, tuning_word_i, amplitude_i,
        input  busy_o, sample_out_o, pos_out_o, neg_out_o, out_valid_o
    );
    modport slave (
        input  sample_en_i, start_i, stop_i, tw_load_i, tuning_word_i, amplitude_i,
        output busy_o, sample_out_o, pos_out_o, neg_out_o, out_valid_o
    );
`else
    modport master (
        output sample_en_i, start_i, stop_i, tw_load_i, tuning_word_i,
        input  busy_o, sample_out_o, pos_out_o, neg_out_o, out_valid_o
    );
    modport slave (
        input  sample_en_i, start_i, stop_i, tw_load_i, tuning_word_i,
        output busy_o, sample_out_o, pos_out_o, neg_out_o, out_valid_o
    );
`endif
endinterface

// File: rtl/sine_quarter_lut.sv
// Registered quarter-wave sine ROM: LUT_AW address bits in, DW-1 magnitude bits out, one-cycle latency.
module sine_quarter_lut
    import sine_dds_pkg::*;
#(
    parameter int LUT_AW = 6,
    parameter int DW     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LUT_AW-1:0] addr_i,
    output logic [DW-2:0]     data_o
);
    localparam int N = 2 ** LUT_AW;

    logic [DW-2:0] rom [N];
    logic [DW-2:0] data_q;

    for (genvar gi = 0; gi < N; gi++) begin : g_rom
        localparam int ENTRY = sine_lut_entry(gi, LUT_AW, DW);
        assign rom[gi] = ENTRY[DW-2:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= rom[addr_i];
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/sine_dds.sv
// Sine DDS top: run/drain FSM, phase accumulator, tuning-word shadow, quadrant mirror and output stage.
// SINE_DDS_AMPLITUDE_EN adds the S2 amplitude scaler.
module sine_dds
    import sine_dds_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 6,
    parameter int DW      = 8
) (
    input logic       clk,
    input logic       reset_n,
    sine_dds_if.slave dds
);
    // state | meaning
    // IDLE  | phase held at 0, strobes emit zero samples
    // RUN   | phase advances by tw_active on every strobe
    // DRAIN | still advancing; returns to IDLE on the strobe that wraps the phase

    state_e             state_q;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] tw_shadow_q, tw_active_q;
    logic [PHASE_W:0]   phase_sum;
    logic               wrap;
    logic [1:0]         quad;
    logic [LUT_AW-1:0]  idx, lut_addr;

    assign phase_sum = {1'b0, phase_q} + {1'b0, tw_active_q};
    assign wrap      = phase_sum[PHASE_W];
    assign quad      = phase_q[PHASE_W-1 -: 2];
    assign idx       = phase_q[PHASE_W-3 -: LUT_AW];
    // Odd quadrants read the table backwards; ~idx == N-1-idx
    assign lut_addr  = quad[0] ? ~idx : idx;

    always_comb begin
        phase_d = phase_q;
        if (dds.sample_en_i && state_q != IDLE) begin
            phase_d = phase_sum[PHASE_W-1:0];
            if (state_q == DRAIN && wrap && !dds.start_i) begin
                phase_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            tw_shadow_q <= '0;
            tw_active_q <= '0;
        end else begin
            phase_q <= phase_d;
            if (dds.tw_load_i) begin
                tw_shadow_q <= dds.tuning_word_i;
            end
            if (dds.sample_en_i && state_q != IDLE) begin
                tw_active_q <= tw_shadow_q;
            end
            case (state_q)
                IDLE: begin
                    // Leaving IDLE picks up the shadow so the first step uses the loaded word
                    if (dds.start_i) begin
                        state_q     <= RUN;
                        tw_active_q <= tw_shadow_q;
                    end
                end
                RUN: begin
                    if (dds.stop_i && !dds.start_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dds.start_i) begin
                        state_q <= RUN;
                    end else if (dds.sample_en_i && wrap) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic              s0_valid_q, s0_zero_q;
    logic [1:0]        s0_quad_q;
    logic [LUT_AW-1:0] s0_addr_q;
    logic              s1_valid_q, s1_zero_q;
    logic [1:0]        s1_quad_q;
    logic [DW-2:0]     lut_data;
    logic [DW-2:0]     mag, mag_z;
    logic [DW-1:0]     sample_d, sample_q;
    logic [DW-2:0]     pos_d, pos_q, neg_d, neg_q;
    logic              out_valid_q;
`ifdef SINE_DDS_AMPLITUDE_EN
    logic [7:0]        amp_s1_q;
`endif

    sine_quarter_lut #(
        .LUT_AW (LUT_AW),
        .DW     (DW)
    ) u_lut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr_i  (s0_addr_q),
        .data_o  (lut_data)
    );

`ifdef SINE_DDS_AMPLITUDE_EN
    assign mag = (DW-1)'(((DW+7)'(lut_data) * (DW+7)'({1'b0, amp_s1_q} + 9'd1)) >> 8);
`else
    assign mag = lut_data;
`endif

    always_comb begin
        mag_z    = s1_zero_q ? '0 : mag;
        sample_d = s1_quad_q[1] ? -{1'b0, mag_z} : {1'b0, mag_z};
        pos_d    = s1_quad_q[1] ? '0 : mag_z;
        neg_d    = s1_quad_q[1] ? mag_z : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s0_valid_q  <= 1'b0;
            s0_zero_q   <= 1'b0;
            s0_quad_q   <= '0;
            s0_addr_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_quad_q   <= '0;
`ifdef SINE_DDS_AMPLITUDE_EN
            amp_s1_q    <= '0;
`endif
            out_valid_q <= 1'b0;
            sample_q    <= '0;
            pos_q       <= '0;
            neg_q       <= '0;
        end else begin
            s0_valid_q  <= dds.sample_en_i;
            s0_zero_q   <= (state_q == IDLE);
            s0_quad_q   <= quad;
            s0_addr_q   <= lut_addr;
            s1_valid_q  <= s0_valid_q;
            s1_zero_q   <= s0_zero_q;
            s1_quad_q   <= s0_quad_q;
`ifdef SINE_DDS_AMPLITUDE_EN
            amp_s1_q    <= dds.amplitude_i;
`endif
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sample_q <= sample_d;
                pos_q    <= pos_d;
                neg_q    <= neg_d;
            end
        end
    end

    assign dds.busy_o       = (state_q != IDLE);
    assign dds.sample_out_o = sample_q;
    assign dds.pos_out_o    = pos_q;
    assign dds.neg_out_o    = neg_q;
    assign dds.out_valid_o  = out_valid_q;
endmodule
